memcpy_engine: RTL and testbench

Multi-cycle memory-copy/fill sequencer for the single-cycle datapath. It replaces the bare byte/word counter behind the memcpy instruction. It drives the data-memory port directly while holding the PC with `stall`. It generalises the old counter in three ways: per-unit word/byte selection from alignment, a fill mode, and overlap-safe backward copy (memmove semantics).

---
 rtl/memcpy_engine.sv | 161 ++++++++++++++++
 tb/tb_memcpy_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/memcpy_engine.sv
`default_nettype none
// ============================================================================
// memcpy_engine : copy/fill sequencer driving the data-memory port, stalls PC
// Revision 1.0
// ============================================================================

// Access-size encodings shared with the core's controls.sv.
`ifndef LS_BYTE
`define LS_BYTE 2'b00
`endif
`ifndef LS_WORD
`define LS_WORD 2'b10
`endif

module memcpy_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [7:0]            fill_byte,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_ls_type,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  bytes_left
);

  localparam int WB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(WB);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state, next_state;
  logic [ADDR_WIDTH-1:0] src_cur, dst_cur;
  logic [LEN_WIDTH-1:0]  left;
  logic                  is_fill, back;
  logic [7:0]            fill_val;
  logic [DATA_WIDTH-1:0] buffer;

  logic [ADDR_WIDTH:0]   src_ext, dst_ext, src_end;
  logic                  launch_back;
  logic                  word_unit;
  logic [LEN_WIDTH-1:0]  unit, left_next;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;

  // Overlap test in one extra bit so src+length cannot wrap below dst.
  assign src_ext     = {1'b0, src_addr};
  assign dst_ext     = {1'b0, dst_addr};
  assign src_end     = src_ext + (ADDR_WIDTH+1)'(length);
  assign launch_back = !mode && (dst_ext > src_ext) && (dst_ext < src_end);

  assign word_unit = !back && (dst_cur[OFS-1:0] == '0)
                     && (is_fill || (src_cur[OFS-1:0] == '0))
                     && (left >= LEN_WIDTH'(WB));
  assign unit      = word_unit ? LEN_WIDTH'(WB) : LEN_WIDTH'(1);
  assign left_next = left - unit;
  assign rd_addr   = back ? (src_cur + ADDR_WIDTH'(left) - ADDR_WIDTH'(1)) : src_cur;
  assign wr_addr   = back ? (dst_cur + ADDR_WIDTH'(left) - ADDR_WIDTH'(1)) : dst_cur;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      src_cur  <= '0;
      dst_cur  <= '0;
      left     <= '0;
      is_fill  <= 1'b0;
      back     <= 1'b0;
      fill_val <= '0;
      buffer   <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_cur  <= src_addr;
            dst_cur  <= dst_addr;
            left     <= length;
            is_fill  <= mode;
            back     <= launch_back;
            fill_val <= fill_byte;
          end
        end
        S_READ: buffer <= mem_rdata;
        S_WRITE: begin
          left <= left_next;
          if (!back) begin
            src_cur <= src_cur + ADDR_WIDTH'(unit);
            dst_cur <= dst_cur + ADDR_WIDTH'(unit);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) next_state = S_DONE;
          else              next_state = mode ? S_WRITE : S_READ;
        end
      end
      S_READ:  next_state = S_WRITE;
      S_WRITE: begin
        if (left_next == '0) next_state = S_DONE;
        else                 next_state = is_fill ? S_WRITE : S_READ;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_ls_type = `LS_BYTE;
    mem_wdata   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_READ: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_addr    = rd_addr;
        mem_ls_type = word_unit ? `LS_WORD : `LS_BYTE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_write   = 1'b1;
        mem_addr    = wr_addr;
        mem_ls_type = word_unit ? `LS_WORD : `LS_BYTE;
        mem_wdata   = is_fill ? {WB{fill_val}} : buffer;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
    stall = busy || ((state == S_IDLE) && start);
  end

  assign bytes_left = left;

endmodule

`default_nettype wire

// File: tb/tb_memcpy_engine.sv
`default_nettype none
// ============================================================================
// tb_memcpy_engine : directed bench with a byte-addressed memory model
// Revision 1.0
// ============================================================================

`ifndef LS_BYTE
`define LS_BYTE 2'b00
`endif
`ifndef LS_WORD
`define LS_WORD 2'b10
`endif

module tb_memcpy_engine;

  logic        clk, rstn, start, mode;
  logic [31:0] src_addr, dst_addr, mem_rdata, mem_addr, mem_wdata;
  logic [6:0]  length, bytes_left;
  logic [7:0]  fill_byte;
  logic        mem_read, mem_write, busy, stall, done;
  logic [1:0]  mem_ls_type;

  memcpy_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(7)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_byte(fill_byte), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ls_type(mem_ls_type),
    .mem_wdata(mem_wdata), .busy(busy), .stall(stall), .done(done),
    .bytes_left(bytes_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory; preload port shares the single write process.
  logic [7:0] mem [0:255];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;
  logic [7:0] ma;
  assign ma = mem_addr[7:0];

  always_comb begin
    mem_rdata = '0;
    if (mem_ls_type == `LS_WORD)
      mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    else
      mem_rdata = {24'h0, mem[ma]};
  end

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_ls_type == `LS_WORD) begin
        mem[ma + 8'd1] <= mem_wdata[15:8];
        mem[ma + 8'd2] <= mem_wdata[23:16];
        mem[ma + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Per-run trace
  logic        acc_wr   [64];
  logic [31:0] acc_addr [64];
  logic [1:0]  acc_ls   [64];
  logic [31:0] acc_wd   [64];
  int n_acc, rd_cnt, stall_cnt, done_at, bl_first, both_hi;

  task automatic launch(input logic m, input logic [31:0] s, input logic [31:0] d,
                        input logic [6:0] len, input logic [7:0] f, input bit hold);
    for (int i = 0; i < 64; i++) begin
      acc_wr[i] = 1'b0; acc_addr[i] = '0; acc_ls[i] = '0; acc_wd[i] = '0;
    end
    n_acc = 0; rd_cnt = 0; stall_cnt = 0; done_at = -1; bl_first = -1; both_hi = 0;
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; length = len; fill_byte = f; start = 1'b1;
    #1;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        #1;
      end
      if (stall) stall_cnt++;
      if (mem_read && mem_write) both_hi++;
      if (mem_read) rd_cnt++;
      if ((mem_read || mem_write) && n_acc < 64) begin
        acc_wr[n_acc]   = mem_write;
        acc_addr[n_acc] = mem_addr;
        acc_ls[n_acc]   = mem_ls_type;
        acc_wd[n_acc]   = mem_write ? mem_wdata : 32'h0;
        n_acc++;
      end
      if (k == 1) bl_first = int'(bytes_left);
      if (done) begin
        done_at = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic exp_acc(input int i, input logic wr, input logic [31:0] a,
                         input logic [1:0] ls, input logic [31:0] wd);
    check($sformatf("acc%0d", i), {acc_wr[i], acc_ls[i], acc_addr[i], acc_wd[i]},
          {wr, ls, a, wd});
  endtask

  task automatic preload_src();
    for (int i = 0; i < 8; i++) poke(8'(8'h10 + i), 8'(8'h11 + i));
    for (int i = 0; i < 8; i++) poke(8'(8'h20 + i), 8'h00);
  endtask

  task automatic scen1(input string p);
    launch(1'b0, 32'h10, 32'h20, 7'd8, 8'h00, 1'b0);
    check({p, "_stall"}, stall_cnt, 5);
    check({p, "_done_at"}, done_at, 5);
    check({p, "_nacc"}, n_acc, 4);
    check({p, "_bl_first"}, bl_first, 8);
    exp_acc(0, 1'b0, 32'h10, `LS_WORD, 32'h0);
    exp_acc(1, 1'b1, 32'h20, `LS_WORD, 32'h14131211);
    exp_acc(2, 1'b0, 32'h14, `LS_WORD, 32'h0);
    exp_acc(3, 1'b1, 32'h24, `LS_WORD, 32'h18171615);
    @(negedge clk);
    check({p, "_mem_lo"}, {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h14131211);
    check({p, "_mem_hi"}, {mem[8'h27], mem[8'h26], mem[8'h25], mem[8'h24]}, 32'h18171615);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_byte = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", {busy, stall, done, mem_read, mem_write}, 5'b0);
    check("reset_bus", {bytes_left, mem_addr, mem_wdata}, '0);
    rstn = 1'b1;

    // Aligned word copy
    preload_src();
    scen1("copy_word");
    check("both_strobes", both_hi, 0);

    // Misaligned source: byte units
    preload_src();
    launch(1'b0, 32'h11, 32'h20, 7'd3, 8'h00, 1'b0);
    check("bytecp_stall", stall_cnt, 7);
    check("bytecp_done_at", done_at, 7);
    check("bytecp_nacc", n_acc, 6);
    exp_acc(0, 1'b0, 32'h11, `LS_BYTE, 32'h0);
    exp_acc(1, 1'b1, 32'h20, `LS_BYTE, 32'h12);
    exp_acc(2, 1'b0, 32'h12, `LS_BYTE, 32'h0);
    exp_acc(3, 1'b1, 32'h21, `LS_BYTE, 32'h13);
    exp_acc(4, 1'b0, 32'h13, `LS_BYTE, 32'h0);
    exp_acc(5, 1'b1, 32'h22, `LS_BYTE, 32'h14);
    @(negedge clk);
    check("bytecp_mem", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h00141312);

    // Fill: one word then two bytes
    preload_src();
    launch(1'b1, 32'h11, 32'h20, 7'd6, 8'hA5, 1'b0);
    check("fill_stall", stall_cnt, 4);
    check("fill_done_at", done_at, 4);
    check("fill_reads", rd_cnt, 0);
    check("fill_nacc", n_acc, 3);
    exp_acc(0, 1'b1, 32'h20, `LS_WORD, 32'hA5A5A5A5);
    exp_acc(1, 1'b1, 32'h24, `LS_BYTE, 32'hA5A5A5A5);
    exp_acc(2, 1'b1, 32'h25, `LS_BYTE, 32'hA5A5A5A5);
    @(negedge clk);
    check("fill_mem", {mem[8'h26], mem[8'h25], mem[8'h24], mem[8'h23], mem[8'h20]},
          40'h00A5A5A5A5);

    // Overlapping copy runs backward in bytes
    poke(8'h10, 8'h01); poke(8'h11, 8'h02); poke(8'h12, 8'h03);
    poke(8'h13, 8'h04); poke(8'h14, 8'h00); poke(8'h15, 8'h00);
    launch(1'b0, 32'h10, 32'h12, 7'd4, 8'h00, 1'b0);
    check("back_stall", stall_cnt, 9);
    check("back_done_at", done_at, 9);
    exp_acc(0, 1'b0, 32'h13, `LS_BYTE, 32'h0);
    exp_acc(1, 1'b1, 32'h15, `LS_BYTE, 32'h04);
    exp_acc(2, 1'b0, 32'h12, `LS_BYTE, 32'h0);
    exp_acc(3, 1'b1, 32'h14, `LS_BYTE, 32'h03);
    exp_acc(6, 1'b0, 32'h10, `LS_BYTE, 32'h0);
    exp_acc(7, 1'b1, 32'h12, `LS_BYTE, 32'h01);
    @(negedge clk);
    check("back_mem", {mem[8'h12], mem[8'h13], mem[8'h14], mem[8'h15]}, 32'h01020304);

    // Length zero with start held through DONE
    launch(1'b0, 32'h10, 32'h20, 7'd0, 8'h00, 1'b1);
    check("len0_stall", stall_cnt, 1);
    check("len0_done_at", done_at, 1);
    check("len0_nacc", n_acc, 0);
    @(posedge clk); #1;
    check("len0_after", {done, busy, mem_read, mem_write}, 4'b0);

    // Reset during the second write of an aligned copy
    preload_src();
    @(negedge clk);
    mode = 1'b0; src_addr = 32'h10; dst_addr = 32'h20; length = 7'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre", {mem_write, mem_addr}, {1'b1, 32'h24});
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst_mid", {busy, stall, done, mem_read, mem_write}, 5'b0);
    check("rst_left", bytes_left, 7'd0);
    rstn = 1'b1;
    preload_src();
    scen1("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
